// File: rtl/mem_access_stage_pkg.sv
// Shared constants and types for the memory-access stage.
// Imported by the stage, its load extender and the bench.
package mem_access_stage_pkg;

    localparam logic [1:0] WB_ALU    = 2'd0;
    localparam logic [1:0] WB_MEM    = 2'd1;
    localparam logic [1:0] WB_PCNEXT = 2'd2;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;

    typedef struct packed {
        logic        we;
        logic [4:0]  rd;
        logic [31:0] alu;
        logic [31:0] sdata;
        logic [31:0] pc;
        logic [1:0]  src;
        logic        ld;
        logic [2:0]  f3;
    } mem_op_t;

    // Size lives in f3[1:0]; anything wider than a half is treated as a word.
    function automatic logic misaligned(input logic [2:0] f3,
                                        input logic [1:0] a);
        logic r;
        case (f3[1:0])
            2'b00:   r = 1'b0;
            2'b01:   r = a[0];
            default: r = |a;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mem_access_stage_load_extend.sv
// Load lane selection and sign/zero extension.
// Purely combinational; fed by the captured address offset and funct3.
module load_extend
    import mem_access_stage_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  off_i,
    input  logic [2:0]  f3_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    always_comb begin
        case (off_i)
            2'd0:    byte_s = rdata_i[7:0];
            2'd1:    byte_s = rdata_i[15:8];
            2'd2:    byte_s = rdata_i[23:16];
            default: byte_s = rdata_i[31:24];
        endcase
        half_s = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    end

    always_comb begin
        case (f3_i)
            F3_B:    data_o = {{24{byte_s[7]}}, byte_s};
            F3_BU:   data_o = {24'd0, byte_s};
            F3_H:    data_o = {{16{half_s[15]}}, half_s};
            F3_HU:   data_o = {16'd0, half_s};
            default: data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: issues loads/stores on a valid/ready
// data port and presents a registered writeback bundle.
module mem_access_stage
    import mem_access_stage_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic        _clk,
    input  logic        _reset,
    input  logic        _in_valid,
    output logic        _in_ready,
    input  logic        _in_we,
    input  logic [4:0]  _in_rd,
    input  logic [31:0] _in_alu,
    input  logic [31:0] _in_sdata,
    input  logic [31:0] _in_pc,
    input  logic [1:0]  _in_sig_src,
    input  logic        _in_ld,
    input  logic        _in_st,
    input  logic [2:0]  _in_f3,
    output logic        _mem_req,
    input  logic        _mem_rdy,
    output logic        _mem_wr,
    output logic [31:0] _mem_addr,
    output logic [31:0] _mem_wdata,
    output logic [3:0]  _mem_wstrb,
    input  logic        _mem_rvalid,
    input  logic [31:0] _mem_rdata,
    output logic        _wb_we,
    output logic [4:0]  _wb_rd,
    output logic [31:0] _wb_alu,
    output logic [31:0] _wb_mem,
    output logic [31:0] _wb_pc,
    output logic [1:0]  _wb_sig_src,
    output logic        _exc_misalign,
    output logic        _exc_buserr
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    logic [1:0]    state_q, state_d;
    mem_op_t       op_q, op_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic        wb_we_q, wb_we_d;
    logic [4:0]  wb_rd_q, wb_rd_d;
    logic [31:0] wb_alu_q, wb_alu_d;
    logic [31:0] wb_mem_q, wb_mem_d;
    logic [31:0] wb_pc_q, wb_pc_d;
    logic [1:0]  wb_src_q, wb_src_d;
    logic        mis_q, mis_d;
    logic        berr_q, berr_d;

    logic        is_mem;
    logic        load_done;
    logic [1:0]  off;
    logic [31:0] ld_data;
    logic [3:0]  strb;
    logic [31:0] wdata;

    assign is_mem = _in_ld | _in_st;
    assign off    = op_q.alu[1:0];

    load_extend u_ext (
        .rdata_i (_mem_rdata),
        .off_i   (off),
        .f3_i    (op_q.f3),
        .data_o  (ld_data)
    );

    always_comb begin
        case (op_q.f3[1:0])
            2'b00: begin
                strb  = 4'b0001 << off;
                wdata = {4{op_q.sdata[7:0]}};
            end
            2'b01: begin
                strb  = off[1] ? 4'b1100 : 4'b0011;
                wdata = {2{op_q.sdata[15:0]}};
            end
            default: begin
                strb  = 4'b1111;
                wdata = op_q.sdata;
            end
        endcase
    end

    // A response is only honoured for a load that has been granted,
    // including the same-cycle grant+response shortcut from REQ.
    assign load_done = _mem_rvalid & op_q.ld &
                       ((state_q == ST_REQ & _mem_rdy) |
                        (state_q == ST_WAIT));

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        cnt_d    = cnt_q;
        wb_we_d  = 1'b0;
        wb_rd_d  = wb_rd_q;
        wb_alu_d = wb_alu_q;
        wb_mem_d = wb_mem_q;
        wb_pc_d  = wb_pc_q;
        wb_src_d = wb_src_q;
        mis_d    = 1'b0;
        berr_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (_in_valid) begin
                    if (!is_mem) begin
                        wb_we_d  = _in_we;
                        wb_rd_d  = _in_rd;
                        wb_alu_d = _in_alu;
                        wb_pc_d  = _in_pc;
                        wb_src_d = _in_sig_src;
                    end else if (misaligned(_in_f3, _in_alu[1:0])) begin
                        mis_d = 1'b1;
                    end else begin
                        op_d.we    = _in_we;
                        op_d.rd    = _in_rd;
                        op_d.alu   = _in_alu;
                        op_d.sdata = _in_sdata;
                        op_d.pc    = _in_pc;
                        op_d.src   = _in_sig_src;
                        op_d.ld    = _in_ld;
                        op_d.f3    = _in_f3;
                        cnt_d      = '0;
                        state_d    = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                if (_mem_rdy) begin
                    state_d = op_q.ld ? ST_WAIT : ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (!_mem_rvalid) begin
                    if (cnt_q == CNT_LAST) begin
                        berr_d  = 1'b1;
                        cnt_d   = '0;
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (load_done) begin
            wb_we_d  = op_q.we;
            wb_rd_d  = op_q.rd;
            wb_alu_d = op_q.alu;
            wb_mem_d = ld_data;
            wb_pc_d  = op_q.pc;
            wb_src_d = op_q.src;
            state_d  = ST_IDLE;
        end
    end

    always_ff @(posedge _clk or posedge _reset) begin
        if (_reset) begin
            state_q  <= ST_IDLE;
            op_q     <= '0;
            cnt_q    <= '0;
            wb_we_q  <= 1'b0;
            wb_rd_q  <= '0;
            wb_alu_q <= '0;
            wb_mem_q <= '0;
            wb_pc_q  <= '0;
            wb_src_q <= '0;
            mis_q    <= 1'b0;
            berr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            wb_we_q  <= wb_we_d;
            wb_rd_q  <= wb_rd_d;
            wb_alu_q <= wb_alu_d;
            wb_mem_q <= wb_mem_d;
            wb_pc_q  <= wb_pc_d;
            wb_src_q <= wb_src_d;
            mis_q    <= mis_d;
            berr_q   <= berr_d;
        end
    end

    assign _in_ready     = (state_q == ST_IDLE);
    assign _mem_req      = (state_q == ST_REQ);
    assign _mem_wr       = ~op_q.ld;
    assign _mem_addr     = {op_q.alu[31:2], 2'b00};
    assign _mem_wdata    = wdata;
    assign _mem_wstrb    = strb;
    assign _wb_we        = wb_we_q;
    assign _wb_rd        = wb_rd_q;
    assign _wb_alu       = wb_alu_q;
    assign _wb_mem       = wb_mem_q;
    assign _wb_pc        = wb_pc_q;
    assign _wb_sig_src   = wb_src_q;
    assign _exc_misalign = mis_q;
    assign _exc_buserr   = berr_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: directed vectors checked against a
// transaction-level model every cycle plus hand-computed literals.
module tb_mem_access_stage;
    import mem_access_stage_pkg::*;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0, in_ready;
    logic        in_we = 1'b0;
    logic [4:0]  in_rd = '0;
    logic [31:0] in_alu = '0, in_sdata = '0, in_pc = '0;
    logic [1:0]  in_src = '0;
    logic        in_ld = 1'b0, in_st = 1'b0;
    logic [2:0]  in_f3 = '0;
    logic        mem_req, mem_rdy = 1'b0, mem_wr;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_alu, wb_mem, wb_pc;
    logic [1:0]  wb_src;
    logic        exc_mis, exc_berr;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mem_access_stage #(.TIMEOUT(TMO)) dut (
        ._clk(clk), ._reset(rst),
        ._in_valid(in_valid), ._in_ready(in_ready),
        ._in_we(in_we), ._in_rd(in_rd), ._in_alu(in_alu),
        ._in_sdata(in_sdata), ._in_pc(in_pc), ._in_sig_src(in_src),
        ._in_ld(in_ld), ._in_st(in_st), ._in_f3(in_f3),
        ._mem_req(mem_req), ._mem_rdy(mem_rdy), ._mem_wr(mem_wr),
        ._mem_addr(mem_addr), ._mem_wdata(mem_wdata),
        ._mem_wstrb(mem_wstrb), ._mem_rvalid(mem_rvalid),
        ._mem_rdata(mem_rdata),
        ._wb_we(wb_we), ._wb_rd(wb_rd), ._wb_alu(wb_alu),
        ._wb_mem(wb_mem), ._wb_pc(wb_pc), ._wb_sig_src(wb_src),
        ._exc_misalign(exc_mis), ._exc_buserr(exc_berr)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t",
                     name, act, exp, $time);
        end
    endtask

    function automatic int nbytes(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] rdata,
                                             input logic [31:0] addr,
                                             input logic [2:0] f3);
        int n = nbytes(f3);
        int sh = 8 * int'(addr % 4);
        longint unsigned mask = (64'd1 << (8 * n)) - 1;
        longint unsigned v = ({32'd0, rdata} >> sh) & mask;
        if (!f3[2] && ((v >> (8 * n - 1)) & 1) == 1) v = v | ~mask;
        return v[31:0];
    endfunction

    function automatic logic [3:0] ref_strb(input logic [31:0] addr,
                                            input logic [2:0] f3);
        int s = ((1 << nbytes(f3)) - 1) << int'(addr % 4);
        return s[3:0];
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [31:0] sd,
                                              input logic [2:0] f3);
        logic [31:0] w;
        int n = nbytes(f3);
        for (int i = 0; i < 4; i++) w[8*i +: 8] = sd[8*(i % n) +: 8];
        return w;
    endfunction

    // Transaction-level model: one outstanding op, granted flag, wait count.
    logic        m_busy = 0, m_granted = 0;
    int          m_wait = 0;
    logic        c_we = 0, c_ld = 0;
    logic [4:0]  c_rd = 0;
    logic [31:0] c_addr = 0, c_sdata = 0, c_pc = 0;
    logic [1:0]  c_src = 0;
    logic [2:0]  c_f3 = 0;
    logic        e_we = 0, e_mis = 0, e_berr = 0;
    logic [4:0]  e_rd = 0;
    logic [31:0] e_alu = 0, e_mem = 0, e_pc = 0;
    logic [1:0]  e_src = 0;

    always @(posedge clk or posedge rst) begin
        e_we = 0; e_mis = 0; e_berr = 0;
        if (rst) begin
            m_busy = 0; m_granted = 0; m_wait = 0;
            e_rd = 0; e_alu = 0; e_mem = 0; e_pc = 0; e_src = 0;
        end else if (!m_busy) begin
            if (in_valid) begin
                if (!in_ld && !in_st) begin
                    e_we = in_we; e_rd = in_rd; e_alu = in_alu;
                    e_pc = in_pc; e_src = in_src;
                end else if (in_alu % nbytes(in_f3) != 0) begin
                    e_mis = 1;
                end else begin
                    m_busy = 1; m_granted = 0; m_wait = 0;
                    c_we = in_we; c_rd = in_rd; c_addr = in_alu;
                    c_sdata = in_sdata; c_pc = in_pc; c_src = in_src;
                    c_ld = in_ld; c_f3 = in_f3;
                end
            end
        end else begin
            if (!m_granted && mem_rdy) begin
                if (!c_ld) m_busy = 0;
                else m_granted = 1;
            end else if (m_granted && !mem_rvalid) begin
                m_wait++;
                if (m_wait == TMO) begin e_berr = 1; m_busy = 0; end
            end
            if (m_busy && m_granted && mem_rvalid) begin
                e_we = c_we; e_rd = c_rd; e_alu = c_addr; e_pc = c_pc;
                e_src = c_src; e_mem = ref_load(mem_rdata, c_addr, c_f3);
                m_busy = 0;
            end
        end
    end

    always @(posedge clk) begin
        #1;
        chk("in_ready", in_ready, !m_busy);
        chk("mem_req", mem_req, m_busy && !m_granted);
        if (m_busy && !m_granted) begin
            chk("mem_addr", mem_addr, c_addr & 32'hFFFF_FFFC);
            chk("mem_wr", mem_wr, !c_ld);
            chk("mem_wstrb", mem_wstrb, ref_strb(c_addr, c_f3));
            if (!c_ld) chk("mem_wdata", mem_wdata, ref_wdata(c_sdata, c_f3));
        end
        chk("wb_we", wb_we, e_we);
        chk("wb_rd", wb_rd, e_rd);
        chk("wb_alu", wb_alu, e_alu);
        chk("wb_mem", wb_mem, e_mem);
        chk("wb_pc", wb_pc, e_pc);
        chk("wb_src", wb_src, e_src);
        chk("exc_misalign", exc_mis, e_mis);
        chk("exc_buserr", exc_berr, e_berr);
    end

    task automatic issue(input logic we, input logic [4:0] rd,
                         input logic [31:0] alu, input logic [31:0] sd,
                         input logic [31:0] pc, input logic [1:0] src,
                         input logic ld, input logic st,
                         input logic [2:0] f3);
        in_we = we; in_rd = rd; in_alu = alu; in_sdata = sd;
        in_pc = pc; in_src = src; in_ld = ld; in_st = st; in_f3 = f3;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic imm_op(input logic ld, input logic st,
                          input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] sd, input logic [31:0] rd_word);
        mem_rdy = 1'b1; mem_rvalid = ld; mem_rdata = rd_word;
        issue(1'b1, 5'd3, a, sd, 32'h40, WB_MEM, ld, st, f3);
        @(negedge clk);
        mem_rdy = 1'b0; mem_rvalid = 1'b0;
    endtask

    logic got;

    initial begin
        repeat (2) @(negedge clk);
        chk("reset_wb_we", wb_we, 0);
        chk("reset_ready", in_ready, 1);
        chk("reset_wb_alu", wb_alu, 0);
        rst = 1'b0;
        @(negedge clk);

        issue(1'b1, 5'd5, 32'h1234, 0, 32'h100, WB_ALU, 0, 0, F3_W);
        chk("alu_we", wb_we, 1);
        chk("alu_rd", wb_rd, 5);
        chk("alu_val", wb_alu, 32'h1234);
        chk("alu_noreq", mem_req, 0);
        chk("model_alu", e_alu, 32'h1234);
        @(negedge clk);
        chk("alu_we_drop", wb_we, 0);

        issue(1'b1, 5'd0, 32'h77, 0, 32'h104, WB_PCNEXT, 0, 0, F3_W);
        chk("rd0_we", wb_we, 1);

        imm_op(1, 0, F3_B, 32'h1003, 0, 32'h8012_3456);
        chk("lb_mem", wb_mem, 32'hFFFF_FF80);
        chk("model_lb", e_mem, 32'hFFFF_FF80);
        chk("lb_we", wb_we, 1);
        imm_op(1, 0, F3_BU, 32'h1003, 0, 32'h8012_3456);
        chk("lbu_mem", wb_mem, 32'h0000_0080);
        imm_op(1, 0, F3_H, 32'h0012, 0, 32'h8001_0000);
        chk("lh_mem", wb_mem, 32'hFFFF_8001);
        imm_op(1, 0, F3_HU, 32'h0012, 0, 32'h8001_0000);
        chk("lhu_mem", wb_mem, 32'h0000_8001);
        imm_op(1, 0, F3_B, 32'h1001, 0, 32'h0000_7F00);
        chk("lb_pos", wb_mem, 32'h0000_007F);
        imm_op(0, 1, F3_B, 32'h0011, 32'h55, 0);
        chk("sb_we", wb_we, 0);

        mem_rdy = 1'b0;
        issue(1'b1, 5'd6, 32'h2002, 32'hABCD, 32'h200, WB_ALU, 0, 1, F3_H);
        chk("sh_req", mem_req, 1);
        chk("sh_addr", mem_addr, 32'h2000);
        chk("sh_strb", mem_wstrb, 4'b1100);
        chk("sh_wdata", mem_wdata, 32'hABCD_ABCD);
        chk("sh_wr", mem_wr, 1);
        mem_rdy = 1'b1;
        @(negedge clk);
        mem_rdy = 1'b0;
        chk("sh_we", wb_we, 0);
        chk("sh_ready", in_ready, 1);

        issue(1'b1, 5'd8, 32'h3001, 0, 32'h300, WB_MEM, 1, 0, F3_W);
        chk("mis_pulse", exc_mis, 1);
        chk("mis_noreq", mem_req, 0);
        chk("mis_ready", in_ready, 1);
        @(negedge clk);
        chk("mis_drop", exc_mis, 0);

        issue(1'b1, 5'd9, 32'h3004, 0, 32'h304, WB_MEM, 1, 0, F3_W);
        repeat (2) @(negedge clk);
        chk("lw_stall_ready", in_ready, 0);
        chk("lw_stall_addr", mem_addr, 32'h3004);
        mem_rdy = 1'b1;
        @(negedge clk);
        mem_rdy = 1'b0;
        @(negedge clk);
        mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_BABE;
        @(negedge clk);
        mem_rvalid = 1'b0;
        chk("lw_we", wb_we, 1);
        chk("lw_mem", wb_mem, 32'hCAFE_BABE);
        chk("lw_rd", wb_rd, 9);
        @(negedge clk);
        chk("lw_single", wb_we, 0);

        mem_rdy = 1'b1;
        issue(1'b1, 5'd10, 32'h4000, 0, 32'h400, WB_MEM, 1, 0, F3_W);
        @(negedge clk);
        mem_rdy = 1'b0;
        got = 1'b0;
        for (int k = 1; k <= 10 && !got; k++) begin
            @(negedge clk);
            if (exc_berr) begin
                got = 1'b1;
                chk("berr_cycles", k, TMO);
                chk("berr_ready", in_ready, 1);
                chk("berr_we", wb_we, 0);
            end
        end
        if (!got) chk("berr_seen", 0, 1);
        mem_rvalid = 1'b1; mem_rdata = 32'h1111_2222;
        @(negedge clk);
        mem_rvalid = 1'b0;
        chk("late_rvalid_we", wb_we, 0);

        mem_rdy = 1'b1;
        issue(1'b1, 5'd11, 32'h5000, 0, 32'h500, WB_MEM, 1, 0, F3_W);
        @(negedge clk);
        mem_rdy = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = 32'h5555_AAAA;
        @(negedge clk);
        mem_rvalid = 1'b0;
        chk("rst_abandon_we", wb_we, 0);
        chk("rst_abandon_mem", wb_mem, 0);
        repeat (2) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Memory-access pipeline stage between execute and the register-writeback stage.
- Takes one instruction per handshake from execute and performs any load or store over a valid/ready data-memory port.
- Aligns and sign- or zero-extends load data, then presents a registered writeback bundle: we, rd, ALU result, memory result, pc, wb-source select.
- Stalls upstream while a memory transaction is outstanding; flags misaligned accesses and bus timeouts.

Parameters:
- TIMEOUT, 255: maximum cycles spent in WAIT_RSP before a bus-error is flagged.

Ports:
- _clk  in  1  clock, rising edge.
- _reset  in  1  reset; asynchronous, active-high.
- _in_valid  in  1  execute presents an instruction.
- _in_ready  out  1  stage can accept; equals (state==IDLE).
- _in_we  in  1  instruction writes rd.
- _in_rd  in  5  destination register.
- _in_alu  in  32  ALU result; effective address for load/store.
- _in_sdata  in  32  store data (rs2).
- _in_pc  in  32  instruction pc.
- _in_sig_src  in  2  wb source select: ALU=0, MEM=1, PCNEXT=2.
- _in_ld  in  1  load.
- _in_st  in  1  store.
- _in_f3  in  3  RV32 funct3 size/sign: 0=B, 1=H, 2=W, 4=BU, 5=HU.
- _mem_req  out  1  request valid.
- _mem_rdy  in  1  request accepted this cycle.
- _mem_wr  out  1  request is a write.
- _mem_addr  out  32  word-aligned address ({_in_alu[31:2],2'b00}).
- _mem_wdata  out  32  store data replicated into byte lanes.
- _mem_wstrb  out  4  byte enables.
- _mem_rvalid  in  1  response valid, one cycle.
- _mem_rdata  in  32  read word.
- _wb_we  out  1  to writeback.
- _wb_rd  out  5  to writeback.
- _wb_alu  out  32  to writeback.
- _wb_mem  out  32  extended load value.
- _wb_pc  out  32  to writeback.
- _wb_sig_src  out  2  to writeback.
- _exc_misalign  out  1  one-cycle pulse.
- _exc_buserr  out  1  one-cycle pulse.

Behaviour:
- Reset (async): state=IDLE; all _wb_* outputs 0, _mem_req 0, exception pulses 0, timeout counter 0. Reset mid-transaction abandons it: no writeback, and any late _mem_rvalid is ignored.
- States: IDLE, REQ, WAIT_RSP.
- IDLE, accept (_in_valid && _in_ready), by instruction type:
  - Neither ld nor st: latch the bundle into _wb_* on the next edge; 1-cycle latency; stay IDLE.
  - Misaligned (H with addr[0]!=0; W with addr[1:0]!=0): no memory request; _wb_we=0; _exc_misalign=1 for one cycle; stay IDLE.
  - Otherwise: capture the instruction into internal registers; go to REQ.
- Every cycle without a completed instruction: _wb_we=0. Other _wb_* fields hold their last values.
- REQ: _mem_req=1 with stable addr/wr/wdata/wstrb until _mem_rdy.
  - On _mem_rdy: a store completes (_wb_we=0, go IDLE); a load goes to WAIT_RSP.
  - _mem_rdy and _mem_rvalid in the same cycle as the request are legal; for a load, complete directly without visiting WAIT_RSP.
- WAIT_RSP: on _mem_rvalid, extract the lane by addr[1:0] and extend per f3. Drive _wb_mem, _wb_we=captured we, and the other captured fields; go IDLE.
- Timeout: counter increments each cycle in WAIT_RSP. When it reaches TIMEOUT without a response: _exc_buserr pulse, _wb_we=0, go IDLE.
- Store lanes:
  - B: wstrb=1<<a[1:0]; wdata={4{sdata[7:0]}}.
  - H: wstrb=a[1]?1100:0011; wdata={2{sdata[15:0]}}.
  - W: wstrb=1111.
- A writeback with rd==0 is still emitted; filtering rd==0 is the writeback stage's job.
- Load-result latency from acceptance: best case 2 cycles (rdy+rvalid immediate).

Decomposition:
- Shared package/header constants: wb-source codes (ALU/MEM/PCNEXT), funct3 size codes, state encodings.
- One natural sub-module, load_extend: combinational lane select plus sign/zero extension from (rdata, addr[1:0], f3).

Test Plan:
- ALU op, rd=5, alu=0x1234, sig_src=0 -> next cycle _wb_we=1, _wb_rd=5, _wb_alu=0x1234; no _mem_req.
- LB addr=0x1003, rdata=0x80xxxxxx, rdy and rvalid immediate -> _wb_mem=0xFFFFFF80. Same with LBU -> 0x00000080.
- SH addr=0x2002, sdata=0xABCD -> _mem_addr=0x2000, wstrb=1100, wdata=0xABCDABCD, _wb_we=0.
- LW addr=0x3001 -> _exc_misalign pulse; no _mem_req; _in_ready stays 1.
- LW with _mem_rdy low for 3 cycles, rvalid 2 cycles later -> _in_ready=0 throughout; single writeback; request fields stable while waiting.
- TIMEOUT=4 with no rvalid -> _exc_buserr after 4 WAIT_RSP cycles, state IDLE. Separately, assert _reset in WAIT_RSP, then give rvalid -> no writeback.
